// File: rtl/seq_ctrl_if.sv
// seq_ctrl_if: sequence-controller bundle between the counter/IR side and the controller
interface seq_ctrl_if #(parameter int SEQW = 4);
    logic [SEQW-1:0] t;
    logic [15:0] ir;
    logic start, ien, fgi, fgo;
    logic sc_en, sc_clr;
    logic [2**SEQW-1:0] tdec;
    logic [2:0] phase, op;
    logic i_bit, ien_clr, instr_done, halted, err;
    modport master(
        output t, ir, start, ien, fgi, fgo,
        input sc_en, sc_clr, tdec, phase, op, i_bit, ien_clr, instr_done, halted, err
    );
    modport slave(
        input t, ir, start, ien, fgi, fgo,
        output sc_en, sc_clr, tdec, phase, op, i_bit, ien_clr, instr_done, halted, err
    );
endinterface

// File: rtl/seq_ctrl.sv
// seq_ctrl: basic-computer sequence controller (run/interrupt flags, phase decode, counter control)
module seq_ctrl #(parameter int SEQW = 4) (
    input logic clk,
    input logic rst,
    seq_ctrl_if.slave bus
);
    localparam int N = 2**SEQW;
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, INDIRECT, EXEC, INTR} phase_t;
    logic s, r, err_q, i_q;
    logic [2:0] op_q;
    logic run, early, done, timeout;
    // reset masks the outputs in its own cycle, not only from the next one
    assign run = s && !rst;
    assign early = bus.t < SEQW'(3);
    assign done = run && !r && (
        (bus.t == SEQW'(3) && op_q == 3'd7) ||
        (bus.t == SEQW'(4) && (op_q == 3'd3 || op_q == 3'd4)) ||
        (bus.t == SEQW'(5) && (op_q <= 3'd2 || op_q == 3'd5)) ||
        (bus.t == SEQW'(6) && op_q == 3'd6));
    assign bus.ien_clr = run && r && bus.t == SEQW'(2);
    assign timeout = run && (&bus.t) && !done;
    assign bus.instr_done = done;
    assign bus.sc_clr = (!run && bus.start) || done || bus.ien_clr || timeout;
    assign bus.sc_en = run && !bus.sc_clr;
    assign bus.halted = !run;
    assign bus.err = err_q;
    assign bus.op = op_q;
    assign bus.i_bit = i_q;
    assign bus.tdec = {{(N-1){1'b0}}, 1'b1} << bus.t;
    // phase is a pure decode of the flags and the counter value
    always_comb begin
        bus.phase = !run ? IDLE : r ? INTR : bus.t < SEQW'(2) ? FETCH :
                    bus.t == SEQW'(2) ? DECODE :
                    (bus.t == SEQW'(3) && op_q != 3'd7 && i_q) ? INDIRECT : EXEC;
    end
    // run/interrupt flags, latched instruction fields and sticky timeout error
    always_ff @(posedge clk) begin
        if (rst) begin
            s <= 1'b0;
            r <= 1'b0;
            op_q <= 3'd0;
            i_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (!s && bus.start) s <= 1'b1;
            if (s && !r && bus.t == SEQW'(2)) begin
                op_q <= bus.ir[14:12];
                i_q <= bus.ir[15];
            end
            if (done && bus.t == SEQW'(3) && bus.ir == 16'h7001) s <= 1'b0;
            if (timeout) begin
                err_q <= 1'b1;
                s <= 1'b0;
            end
            if (bus.ien_clr) r <= 1'b0;
            else if (s && !r && !early && bus.ien && (bus.fgi || bus.fgo)) r <= 1'b1;
        end
    end
endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: scoreboard bench for seq_ctrl with a behavioural sequence counter
module tb_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    seq_ctrl_if #(.SEQW(4)) bus();
    seq_ctrl #(.SEQW(4)) dut(.clk(clk), .rst(rst), .bus(bus));
    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, INDIR = 3'd3, EXEC = 3'd4, INTR = 3'd5;
    int total = 0;
    int bad = 0;
    logic stuck = 1'b0;
    logic [3:0] stuck_t = 4'd0;
    logic [9:0] sb[$];
    logic [9:0] exp_v;
    logic [9:0] obs;
    assign obs = {bus.t, bus.phase, bus.instr_done, bus.ien_clr, bus.sc_clr};
    // external sequence counter; stuck lets a test pin t to any value
    always @(posedge clk)
        bus.t <= (rst || bus.sc_clr) ? 4'd0 : stuck ? stuck_t : bus.sc_en ? bus.t + 4'd1 : bus.t;
    // completion and interrupt-clear pulses must be exclusive and always clear the counter
    always @(negedge clk)
        if (bus.instr_done || bus.ien_clr) begin
            total++;
            if ((bus.instr_done && bus.ien_clr) || !bus.sc_clr) begin
                bad++;
                $display("FAIL pulse_rule: done=%b ien_clr=%b sc_clr=%b", bus.instr_done, bus.ien_clr, bus.sc_clr);
            end
        end
    function automatic logic [9:0] ent(int t, logic [2:0] ph, logic d, logic c, logic s);
        return {4'(t), ph, d, c, s};
    endfunction
    task automatic do_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.ien = 1'b0;
        bus.fgi = 1'b0;
        bus.fgo = 1'b0;
        stuck = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask
    task automatic go(input logic [15:0] v);
        bus.ir = v;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({bus.halted, bus.sc_en, bus.err, bus.i_bit, bus.op, bus.tdec} !== {4'b1000, 3'd0, 16'h0001}) begin
            bad++;
            $display("FAIL reset_state: got %b %b %b %b %0d %h", bus.halted, bus.sc_en, bus.err, bus.i_bit, bus.op, bus.tdec);
        end
        repeat (3) sb.push_back(ent(0, IDLE, 0, 0, 0));
        while (sb.size() > 0) begin
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL reset_idle: got %h exp %h", obs, exp_v); end
            @(negedge clk);
        end
    endtask
    task automatic test_lda();
        do_reset();
        go(16'h2010);
        sb.push_back(ent(0, FETCH, 0, 0, 0)); sb.push_back(ent(1, FETCH, 0, 0, 0));
        sb.push_back(ent(2, DECODE, 0, 0, 0)); sb.push_back(ent(3, EXEC, 0, 0, 0));
        sb.push_back(ent(4, EXEC, 0, 0, 0)); sb.push_back(ent(5, EXEC, 1, 0, 1));
        sb.push_back(ent(0, FETCH, 0, 0, 0));
        while (sb.size() > 0) begin
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL lda: got %h exp %h", obs, exp_v); end
            @(negedge clk);
        end
        total++;
        if ({bus.op, bus.i_bit} !== {3'd2, 1'b0}) begin
            bad++;
            $display("FAIL lda_latch: got op=%0d i=%b exp op=2 i=0", bus.op, bus.i_bit);
        end
    endtask
    task automatic test_isz();
        do_reset();
        go(16'hE123);
        sb.push_back(ent(0, FETCH, 0, 0, 0)); sb.push_back(ent(1, FETCH, 0, 0, 0));
        sb.push_back(ent(2, DECODE, 0, 0, 0)); sb.push_back(ent(3, INDIR, 0, 0, 0));
        sb.push_back(ent(4, EXEC, 0, 0, 0)); sb.push_back(ent(5, EXEC, 0, 0, 0));
        sb.push_back(ent(6, EXEC, 1, 0, 1)); sb.push_back(ent(0, FETCH, 0, 0, 0));
        while (sb.size() > 0) begin
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL isz: got %h exp %h", obs, exp_v); end
            @(negedge clk);
        end
        total++;
        if ({bus.op, bus.i_bit} !== {3'd6, 1'b1}) begin
            bad++;
            $display("FAIL isz_latch: got op=%0d i=%b exp op=6 i=1", bus.op, bus.i_bit);
        end
    endtask
    task automatic test_hlt();
        do_reset();
        go(16'h7001);
        sb.push_back(ent(0, FETCH, 0, 0, 0)); sb.push_back(ent(1, FETCH, 0, 0, 0));
        sb.push_back(ent(2, DECODE, 0, 0, 0)); sb.push_back(ent(3, EXEC, 1, 0, 1));
        sb.push_back(ent(0, IDLE, 0, 0, 0)); sb.push_back(ent(0, IDLE, 0, 0, 0));
        while (sb.size() > 0) begin
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL hlt: got %h exp %h", obs, exp_v); end
            @(negedge clk);
        end
        total++;
        if ({bus.halted, bus.sc_en, bus.err} !== 3'b100) begin
            bad++;
            $display("FAIL hlt_state: got halted=%b sc_en=%b err=%b exp 1 0 0", bus.halted, bus.sc_en, bus.err);
        end
    endtask
    task automatic test_intr();
        do_reset();
        go(16'h3000);
        sb.push_back(ent(0, FETCH, 0, 0, 0)); sb.push_back(ent(1, FETCH, 0, 0, 0));
        sb.push_back(ent(2, DECODE, 0, 0, 0)); sb.push_back(ent(3, EXEC, 0, 0, 0));
        while (sb.size() > 0) begin
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL sta: got %h exp %h", obs, exp_v); end
            @(negedge clk);
        end
        bus.ien = 1'b1;
        bus.fgi = 1'b1;
        sb.push_back(ent(4, EXEC, 1, 0, 1)); sb.push_back(ent(0, INTR, 0, 0, 0));
        sb.push_back(ent(1, INTR, 0, 0, 0)); sb.push_back(ent(2, INTR, 0, 1, 1));
        sb.push_back(ent(0, FETCH, 0, 0, 0));
        while (sb.size() > 0) begin
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL intr: got %h exp %h", obs, exp_v); end
            @(negedge clk);
        end
        bus.ien = 1'b0;
        bus.fgi = 1'b0;
        sb.push_back(ent(1, FETCH, 0, 0, 0)); sb.push_back(ent(2, DECODE, 0, 0, 0));
        sb.push_back(ent(3, EXEC, 0, 0, 0)); sb.push_back(ent(4, EXEC, 1, 0, 1));
        sb.push_back(ent(0, FETCH, 0, 0, 0));
        while (sb.size() > 0) begin
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL post_intr: got %h exp %h", obs, exp_v); end
            @(negedge clk);
        end
    endtask
    task automatic test_timeout();
        do_reset();
        go(16'h2010);
        sb.push_back(ent(0, FETCH, 0, 0, 0));
        while (sb.size() > 0) begin
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL to_start: got %h exp %h", obs, exp_v); end
            @(negedge clk);
        end
        stuck_t = 4'd15;
        stuck = 1'b1;
        @(negedge clk);
        stuck = 1'b0;
        sb.push_back(ent(15, EXEC, 0, 0, 1)); sb.push_back(ent(0, IDLE, 0, 0, 0));
        while (sb.size() > 0) begin
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL timeout: got %h exp %h", obs, exp_v); end
            @(negedge clk);
        end
        total++;
        if ({bus.err, bus.halted} !== 2'b11) begin
            bad++;
            $display("FAIL timeout_err: got err=%b halted=%b exp 1 1", bus.err, bus.halted);
        end
        go(16'h2010);
        repeat (3) @(negedge clk);
        total++;
        if ({bus.err, bus.halted} !== 2'b10) begin
            bad++;
            $display("FAIL err_sticky: got err=%b halted=%b exp 1 0", bus.err, bus.halted);
        end
        do_reset();
        total++;
        if (bus.err !== 1'b0) begin bad++; $display("FAIL err_clear: got %b exp 0", bus.err); end
    endtask
    task automatic test_back_to_back();
        do_reset();
        go(16'h2010);
        sb.push_back(ent(0, FETCH, 0, 0, 0));
        while (sb.size() > 0) begin
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL b2b_start: got %h exp %h", obs, exp_v); end
            @(negedge clk);
        end
        bus.start = 1'b1;
        sb.push_back(ent(1, FETCH, 0, 0, 0));
        while (sb.size() > 0) begin
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL start_ignored: got %h exp %h", obs, exp_v); end
            @(negedge clk);
        end
        bus.start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (k > 0) begin sb.push_back(ent(0, FETCH, 0, 0, 0)); sb.push_back(ent(1, FETCH, 0, 0, 0)); end
            sb.push_back(ent(2, DECODE, 0, 0, 0)); sb.push_back(ent(3, EXEC, 0, 0, 0));
            sb.push_back(ent(4, EXEC, 0, 0, 0)); sb.push_back(ent(5, EXEC, 1, 0, 1));
        end
        sb.push_back(ent(0, FETCH, 0, 0, 0));
        while (sb.size() > 0) begin
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL b2b: got %h exp %h", obs, exp_v); end
            @(negedge clk);
        end
    endtask
    task automatic test_rst_mid();
        do_reset();
        go(16'hE123);
        sb.push_back(ent(0, FETCH, 0, 0, 0)); sb.push_back(ent(1, FETCH, 0, 0, 0));
        sb.push_back(ent(2, DECODE, 0, 0, 0)); sb.push_back(ent(3, INDIR, 0, 0, 0));
        while (sb.size() > 0) begin
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL mid_run: got %h exp %h", obs, exp_v); end
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({bus.phase, bus.instr_done, bus.halted, bus.sc_en, bus.sc_clr} !== {IDLE, 4'b0100}) begin
            bad++;
            $display("FAIL in_reset: got ph=%0d done=%b halted=%b en=%b clr=%b", bus.phase, bus.instr_done, bus.halted, bus.sc_en, bus.sc_clr);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) sb.push_back(ent(0, IDLE, 0, 0, 0));
        while (sb.size() > 0) begin
            exp_v = sb.pop_front();
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL after_rst: got %h exp %h", obs, exp_v); end
            @(negedge clk);
        end
        total++;
        if ({bus.op, bus.i_bit, bus.halted} !== {3'd0, 2'b01}) begin
            bad++;
            $display("FAIL rst_fields: got op=%0d i=%b halted=%b exp 0 0 1", bus.op, bus.i_bit, bus.halted);
        end
    endtask
    task automatic test_tdec();
        do_reset();
        for (int k = 0; k < 16; k++) begin
            stuck_t = 4'(k);
            stuck = 1'b1;
            @(negedge clk);
            total++;
            if (bus.tdec !== (16'd1 << k)) begin
                bad++;
                $display("FAIL tdec: t=%0d got %h exp %h", k, bus.tdec, 16'd1 << k);
            end
        end
        stuck = 1'b0;
    endtask
    initial begin
        bus.ir = 16'h0;
        bus.start = 1'b0;
        bus.ien = 1'b0;
        bus.fgi = 1'b0;
        bus.fgo = 1'b0;
        @(negedge clk);
        test_reset();
        test_lda();
        test_isz();
        test_hlt();
        test_intr();
        test_timeout();
        test_back_to_back();
        test_rst_mid();
        test_tdec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end
endmodule
